execute_pipe: RTL

EXECUTE_PIPE -- requirements
Module: execute_pipe

---
 rtl/execute_pipe_if.sv | 35 +++
 rtl/execute_pipe.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/execute_pipe_if.sv
// Issue/retire bundle between decode, the execute pipe and writeback.
// The execute pipe takes the slave view; the upstream/downstream side takes master.
interface execute_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int DEST_W  = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         opcode;
    logic [DATA_W-1:0]  src_a;
    logic [DATA_W-1:0]  src_b;
    logic [DATA_W-1:0]  imm;
    logic [SHAMT_W-1:0] shamt;
    logic [DEST_W-1:0]  dest;
    logic [DATA_W-1:0]  pc;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  wb_data;
    logic [DEST_W-1:0]  wb_dest;
    logic               wb_en;
    logic               br_taken;
    logic [DATA_W-1:0]  br_target;

    modport master (
        output in_valid, opcode, src_a, src_b, imm, shamt, dest, pc, out_ready,
        input  in_ready, out_valid, wb_data, wb_dest, wb_en, br_taken, br_target
    );

    modport slave (
        input  in_valid, opcode, src_a, src_b, imm, shamt, dest, pc, out_ready,
        output in_ready, out_valid, wb_data, wb_dest, wb_en, br_taken, br_target
    );
endinterface

// File: rtl/execute_pipe.sv
// Single-issue execute stage: one-cycle ALU/branch ops, an iterative shift-add
// multiplier, and a halt state, all feeding one registered result slot.
module execute_pipe #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int DEST_W  = 5
) (
    input  logic          clock,
    input  logic          reset,
    execute_pipe_if.slave bus,
    output logic          halted,
    output logic          busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_SHL = 4'h4;
    localparam logic [3:0] OP_SHR = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_BR  = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hA;
    localparam logic [3:0] OP_MOV = 4'hB;
    localparam logic [3:0] OP_ADI = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hE;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              wen;
        logic              br;
        logic [DATA_W-1:0] tgt;
    } result_t;

    logic [1:0]         state;
    logic               out_valid;
    result_t            out_q;
    result_t            alu_res;
    logic               in_ready;
    logic               accept;

    logic [DATA_W-1:0]  mul_acc;
    logic [DATA_W-1:0]  mul_mcand;
    logic [DATA_W-1:0]  mul_mplier;
    logic [SHAMT_W-1:0] mul_cnt;
    logic [DEST_W-1:0]  mul_dest;
    logic [DATA_W-1:0]  mul_sum;

    // Nothing can load the slot while a multiply runs, so it is always free
    // by the time the product is ready.
    assign in_ready = (state == S_IDLE) && (!out_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_comb begin
        alu_res      = '0;
        alu_res.dest = bus.dest;
        alu_res.wen  = 1'b1;
        case (bus.opcode)
            OP_ADD:  alu_res.data = bus.src_a + bus.src_b;
            OP_SUB:  alu_res.data = bus.src_a - bus.src_b;
            OP_LDI:  alu_res.data = bus.imm;
            OP_SHL:  alu_res.data = bus.src_b << bus.shamt;
            OP_SHR:  alu_res.data = bus.src_b >> bus.shamt;
            OP_AND:  alu_res.data = bus.src_a & bus.src_b;
            OP_OR:   alu_res.data = bus.src_a | bus.src_b;
            OP_XOR:  alu_res.data = bus.src_a ^ bus.src_b;
            OP_MOV:  alu_res.data = bus.src_a;
            OP_ADI:  alu_res.data = bus.src_a + bus.imm;
            OP_BR: begin
                alu_res.wen = 1'b0;
                alu_res.br  = 1'b1;
                alu_res.tgt = bus.pc + bus.imm;
            end
            OP_BNE: begin
                alu_res.wen = 1'b0;
                alu_res.br  = (bus.src_a != bus.src_b);
                alu_res.tgt = bus.pc + bus.imm;
            end
            default: alu_res.wen = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            out_q      <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            mul_dest   <= '0;
        end else begin
            if (out_valid && bus.out_ready)
                out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (bus.opcode)
                            OP_MUL: begin
                                state      <= S_MUL;
                                mul_acc    <= '0;
                                mul_mcand  <= bus.src_a;
                                mul_mplier <= bus.src_b;
                                mul_cnt    <= '0;
                                mul_dest   <= bus.dest;
                            end
                            OP_HLT:  state <= S_HALT;
                            default: begin
                                out_valid <= 1'b1;
                                out_q     <= alu_res;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    // One multiplier bit per cycle; the last bit lands straight in the slot.
                    mul_acc    <= mul_sum;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 1'b1;
                    if (mul_cnt == CNT_LAST) begin
                        state      <= S_IDLE;
                        out_valid  <= 1'b1;
                        out_q.data <= mul_sum;
                        out_q.dest <= mul_dest;
                        out_q.wen  <= 1'b1;
                        out_q.br   <= 1'b0;
                        out_q.tgt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.wb_data   = out_q.data;
    assign bus.wb_dest   = out_q.dest;
    assign bus.wb_en     = out_q.wen;
    assign bus.br_taken  = out_q.br;
    assign bus.br_target = out_q.tgt;
    assign busy          = (state == S_MUL);
    assign halted        = (state == S_HALT);
endmodule
